// File: rtl/spi_flash_responder.sv
// SPI mode-0 slave emulating a small serial NOR flash (RDSR, WREN, WRDI, READ, PP).
// All SPI pins are oversampled on clk_i; memory has a system-side preload port.
module spi_flash_responder #(
  parameter int ADDR_W      = 10,
  parameter int BUSY_CYCLES = 64
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              spi_clk,
  input  logic              spi_cs,
  input  logic              spi_di,
  output logic              spi_do,
  input  logic              ld_we_i,
  input  logic [ADDR_W-1:0] ld_adr_i,
  input  logic [7:0]        ld_dat_i,
  output logic              busy_o,
  output logic              wel_o
);
  localparam int              BCW     = $clog2(BUSY_CYCLES + 1);
  localparam logic [BCW-1:0]  BUSY_LD = BCW'(BUSY_CYCLES);
  localparam logic [1:0]      P_NONE = 2'd0, P_WREN = 2'd1, P_WRDI = 2'd2;

  typedef enum logic [2:0] {S_IDLE, S_CMD, S_ADDR, S_RD, S_WR, S_STAT, S_IGN} state_e;

  logic [2:0]        sck_q, sck_d, cs_q, cs_d;
  logic [1:0]        di_q, di_d, settle_q, settle_d, pend_q, pend_d;
  state_e            state_q, state_d;
  logic [4:0]        cnt_q, cnt_d;
  logic [7:0]        sh_q, sh_d, out_q, out_d, nxt, byte_in, rd_q;
  logic              do_q, do_d, pp_q, pp_d, wrote_q, wrote_d, extra_q, extra_d;
  logic              busy_q, busy_d, wel_q, wel_d, we;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [BCW-1:0]    bcnt_q, bcnt_d;
  logic              sck_rise, sck_fall, cs_fall, cs_rise;
  logic [7:0]        mem [2**ADDR_W];

  assign sck_rise = sck_q[1] & ~sck_q[2];
  assign sck_fall = ~sck_q[1] & sck_q[2];
  // Hold off CS-fall detection until the synchronizer has flushed its reset value,
  // so a CS already low when reset releases does not start a frame.
  assign cs_fall  = ~cs_q[1] & cs_q[2] & (settle_q == 2'd3);
  assign cs_rise  = cs_q[1] & ~cs_q[2];
  assign byte_in  = {sh_q[6:0], di_q[1]};

  always_comb begin
    sck_d    = {sck_q[1:0], spi_clk};
    cs_d     = {cs_q[1:0], spi_cs};
    di_d     = {di_q[0], spi_di};
    settle_d = (settle_q == 2'd3) ? settle_q : settle_q + 2'd1;
    state_d  = state_q;
    cnt_d    = cnt_q;
    sh_d     = sh_q;
    out_d    = out_q;
    do_d     = do_q;
    addr_d   = addr_q;
    pp_d     = pp_q;
    wrote_d  = wrote_q;
    extra_d  = extra_q;
    pend_d   = pend_q;
    busy_d   = busy_q;
    wel_d    = wel_q;
    bcnt_d   = bcnt_q;
    we       = 1'b0;
    nxt      = (state_q == S_RD) ? rd_q : {6'b0, wel_q, busy_q};

    if (busy_q) begin
      bcnt_d = bcnt_q - BCW'(1);
      if (bcnt_q == BCW'(1)) begin
        busy_d = 1'b0;
        wel_d  = 1'b0;
      end
    end

    if (cs_fall) begin
      state_d = S_CMD;
      cnt_d   = '0;
      sh_d    = '0;
      out_d   = '0;
      do_d    = 1'b0;
      pp_d    = 1'b0;
      wrote_d = 1'b0;
      extra_d = 1'b0;
      pend_d  = P_NONE;
    end else if (cs_rise) begin
      state_d = S_IDLE;
      do_d    = 1'b0;
      pp_d    = 1'b0;
      pend_d  = P_NONE;
      if (state_q != S_IDLE) begin
        // extra_q marks clocks beyond the opcode: WREN/WRDI must be exactly 8 bits
        if (!busy_q && !extra_q && pend_q == P_WREN) wel_d = 1'b1;
        if (!busy_q && !extra_q && pend_q == P_WRDI) wel_d = 1'b0;
        if (pp_q) begin
          if (wrote_q) begin
            busy_d = 1'b1;
            bcnt_d = BUSY_LD;
          end else begin
            wel_d = 1'b0;
          end
        end
      end
    end else if (sck_rise) begin
      case (state_q)
        S_CMD: begin
          sh_d  = byte_in;
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd7) begin
            cnt_d   = '0;
            state_d = S_IGN;
            if (!busy_q || byte_in == 8'h05) begin
              case (byte_in)
                8'h05: state_d = S_STAT;
                8'h03: state_d = S_ADDR;
                8'h02: if (wel_q) begin
                  state_d = S_ADDR;
                  pp_d    = 1'b1;
                end
                8'h06: pend_d = P_WREN;
                8'h04: pend_d = P_WRDI;
                default: ;
              endcase
            end
          end
        end
        S_ADDR: begin
          // only the low ADDR_W bits survive the 24-bit shift
          addr_d = {addr_q[ADDR_W-2:0], di_q[1]};
          cnt_d  = cnt_q + 5'd1;
          if (cnt_q == 5'd23) begin
            cnt_d   = '0;
            state_d = pp_q ? S_WR : S_RD;
          end
        end
        S_WR: begin
          sh_d  = byte_in;
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd7) begin
            cnt_d   = '0;
            we      = 1'b1;
            wrote_d = 1'b1;
            addr_d  = {addr_q[ADDR_W-1:8], addr_q[7:0] + 8'd1};
          end
        end
        S_RD, S_STAT: cnt_d = (cnt_q == 5'd7) ? 5'd0 : cnt_q + 5'd1;
        S_IGN:        extra_d = 1'b1;
        default: ;
      endcase
    end else if (sck_fall && (state_q == S_RD || state_q == S_STAT)) begin
      if (cnt_q == 5'd0) begin
        do_d  = nxt[7];
        out_d = {nxt[6:0], 1'b0};
        if (state_q == S_RD) addr_d = addr_q + ADDR_W'(1);
      end else begin
        do_d  = out_q[7];
        out_d = {out_q[6:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sck_q    <= 3'b000;
      cs_q     <= 3'b111;
      di_q     <= 2'b00;
      settle_q <= 2'd0;
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      sh_q     <= '0;
      out_q    <= '0;
      do_q     <= 1'b0;
      addr_q   <= '0;
      pp_q     <= 1'b0;
      wrote_q  <= 1'b0;
      extra_q  <= 1'b0;
      pend_q   <= P_NONE;
      busy_q   <= 1'b0;
      wel_q    <= 1'b0;
      bcnt_q   <= '0;
    end else begin
      sck_q    <= sck_d;
      cs_q     <= cs_d;
      di_q     <= di_d;
      settle_q <= settle_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sh_q     <= sh_d;
      out_q    <= out_d;
      do_q     <= do_d;
      addr_q   <= addr_d;
      pp_q     <= pp_d;
      wrote_q  <= wrote_d;
      extra_q  <= extra_d;
      pend_q   <= pend_d;
      busy_q   <= busy_d;
      wel_q    <= wel_d;
      bcnt_q   <= bcnt_d;
    end
  end

  // Single write port: an SPI page-program byte takes precedence over preload.
  always_ff @(posedge clk_i) begin
    if (we)           mem[addr_q]   <= byte_in;
    else if (ld_we_i) mem[ld_adr_i] <= ld_dat_i;
    rd_q <= mem[addr_q];
  end

  assign spi_do = do_q;
  assign busy_o = busy_q;
  assign wel_o  = wel_q;
endmodule

// File: tb/tb_spi_flash_responder.sv
// Directed bench for spi_flash_responder: a mode-0 SPI master drives frames and
// checks returned bytes, status pins and memory contents read back over SPI.
module tb_spi_flash_responder;
  localparam int AW = 10;
  localparam int BC = 2000;

  logic          clk_i = 1'b0, rst_i = 1'b1;
  logic          spi_clk = 1'b0, spi_cs = 1'b1, spi_di = 1'b0, spi_do;
  logic          ld_we_i = 1'b0, busy_o, wel_o;
  logic [AW-1:0] ld_adr_i = '0;
  logic [7:0]    ld_dat_i = '0, rx;
  int            n_cmp = 0, n_err = 0, busy_len = 0;

  spi_flash_responder #(.ADDR_W(AW), .BUSY_CYCLES(BC)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .spi_clk(spi_clk), .spi_cs(spi_cs),
    .spi_di(spi_di), .spi_do(spi_do), .ld_we_i(ld_we_i), .ld_adr_i(ld_adr_i),
    .ld_dat_i(ld_dat_i), .busy_o(busy_o), .wel_o(wel_o)
  );

  always #5 clk_i = ~clk_i;
  always @(negedge clk_i) if (busy_o) busy_len++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic half();
    repeat (8) @(negedge clk_i);
  endtask

  task automatic ld(input logic [AW-1:0] a, input logic [7:0] d);
    ld_we_i = 1'b1; ld_adr_i = a; ld_dat_i = d;
    @(negedge clk_i);
    ld_we_i = 1'b0;
  endtask

  task automatic cs_lo();
    spi_cs = 1'b0;
    half();
  endtask

  task automatic cs_hi();
    half();
    spi_cs = 1'b1;
    half();
    half();
  endtask

  // Master samples spi_do just before each rising SCK, drives spi_di while SCK is low.
  task automatic xb(input logic [7:0] tx, input int nb, output logic [7:0] r);
    r = '0;
    for (int i = 0; i < nb; i++) begin
      spi_di = tx[7-i];
      half();
      r = {r[6:0], spi_do};
      spi_clk = 1'b1;
      half();
      spi_clk = 1'b0;
    end
  endtask

  task automatic hdr(input logic [7:0] op, input logic [23:0] a, output logic [7:0] r);
    logic [7:0] dummy;
    cs_lo();
    xb(op, 8, r);
    xb(a[23:16], 8, dummy);
    xb(a[15:8], 8, dummy);
    xb(a[7:0], 8, dummy);
  endtask

  initial begin
    repeat (3) @(negedge clk_i);
    chk("rst_do", spi_do, 1'b0);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_wel", wel_o, 1'b0);
    rst_i = 1'b0;
    repeat (4) @(negedge clk_i);
    ld(10'h005, 8'hA5); ld(10'h006, 8'h3C); ld(10'h3FF, 8'h11);
    ld(10'h000, 8'h22); ld(10'h200, 8'h77);

    // plain read of two consecutive bytes
    hdr(8'h03, 24'h000005, rx);
    chk("rd_cmd_do0", rx, 8'h00);
    xb(8'h00, 8, rx); chk("rd_005", rx, 8'hA5);
    xb(8'h00, 8, rx); chk("rd_006", rx, 8'h3C);
    cs_hi();

    // read wraps from top of memory to 0
    hdr(8'h03, 24'h0003FF, rx);
    xb(8'h00, 8, rx); chk("rd_3ff", rx, 8'h11);
    xb(8'h00, 8, rx); chk("rd_wrap_000", rx, 8'h22);
    cs_hi();

    cs_lo(); xb(8'h05, 8, rx); xb(8'h00, 8, rx); chk("rdsr_init", rx, 8'h00); cs_hi();

    cs_lo(); xb(8'h06, 8, rx); cs_hi();
    chk("wren_wel", wel_o, 1'b1);
    cs_lo(); xb(8'h05, 8, rx);
    xb(8'h00, 8, rx); chk("rdsr_wel", rx, 8'h02);
    xb(8'h00, 8, rx); chk("rdsr_repeat", rx, 8'h02);
    cs_hi();

    // page program crossing the 256-byte page boundary
    busy_len = 0;
    hdr(8'h02, 24'h0001FE, rx);
    xb(8'hDE, 8, rx); xb(8'hAD, 8, rx); xb(8'hBE, 8, rx);
    cs_hi();
    chk("pp_busy", busy_o, 1'b1);
    chk("pp_wel", wel_o, 1'b1);
    cs_lo(); xb(8'h05, 8, rx); xb(8'h00, 8, rx); chk("rdsr_busy", rx, 8'h03); cs_hi();
    hdr(8'h03, 24'h0001FE, rx);
    xb(8'h00, 8, rx); chk("rd_while_busy", rx, 8'h00);
    cs_hi();
    chk("still_busy", busy_o, 1'b1);
    for (int i = 0; i < 5000 && busy_o; i++) @(negedge clk_i);
    chk("busy_cleared", busy_o, 1'b0);
    chk("wel_cleared", wel_o, 1'b0);
    chk("busy_len", busy_len, BC);
    cs_lo(); xb(8'h05, 8, rx); xb(8'h00, 8, rx); chk("rdsr_done", rx, 8'h00); cs_hi();

    hdr(8'h03, 24'h0001FE, rx);
    xb(8'h00, 8, rx); chk("pp_1fe", rx, 8'hDE);
    xb(8'h00, 8, rx); chk("pp_1ff", rx, 8'hAD);
    cs_hi();
    hdr(8'h03, 24'h000100, rx); xb(8'h00, 8, rx); chk("pp_100", rx, 8'hBE); cs_hi();
    hdr(8'h03, 24'h000200, rx); xb(8'h00, 8, rx); chk("pp_200_kept", rx, 8'h77); cs_hi();

    // page program without write enable is ignored
    hdr(8'h02, 24'h000005, rx);
    xb(8'h55, 8, rx); chk("pp_nowel_do", rx, 8'h00);
    cs_hi();
    chk("pp_nowel_busy", busy_o, 1'b0);
    hdr(8'h03, 24'h000005, rx); xb(8'h00, 8, rx); chk("pp_nowel_mem", rx, 8'hA5); cs_hi();

    cs_lo(); xb(8'h06, 5, rx); cs_hi();
    chk("wren_5bit", wel_o, 1'b0);
    cs_lo(); xb(8'h06, 8, rx); xb(8'h00, 1, rx); cs_hi();
    chk("wren_9bit", wel_o, 1'b0);
    cs_lo(); xb(8'h06, 8, rx); cs_hi();
    chk("wren_again", wel_o, 1'b1);
    cs_lo(); xb(8'h04, 8, rx); cs_hi();
    chk("wrdi", wel_o, 1'b0);

    // reset in the middle of a read clears WEL and the output
    cs_lo(); xb(8'h06, 8, rx); cs_hi();
    chk("wren_pre_rst", wel_o, 1'b1);
    hdr(8'h03, 24'h000005, rx);
    xb(8'h00, 2, rx); chk("rd_partial", rx, 8'h02);
    half();
    chk("pre_rst_do", spi_do, 1'b1);
    rst_i = 1'b1;
    #1;
    chk("mid_rst_do", spi_do, 1'b0);
    chk("mid_rst_wel", wel_o, 1'b0);
    repeat (3) @(negedge clk_i);
    rst_i = 1'b0;
    half();
    chk("post_rst_do", spi_do, 1'b0);
    spi_cs = 1'b1;
    half(); half();
    hdr(8'h03, 24'h000006, rx); xb(8'h00, 8, rx); chk("post_rst_rd", rx, 8'h3C); cs_hi();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
